// File: rtl/sha2_msg_sched_stream.sv
// SHA-2 message-schedule generator.
// Loads one 16-word block and streams W[0..ROUNDS-1], LANES words per beat,
// with valid/ready handshakes on both sides and zero-bubble block chaining.
// The 16-word window holds W[t..t+15]; lane 0 of each beat is window word 0.
module sha2_msg_sched_stream #(
   parameter int WORD_W = 32,
   parameter int ROUNDS = 64,
   parameter int LANES  = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    abort,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [16*WORD_W-1:0]    in_block,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*WORD_W-1:0] out_words,
   output logic [6:0]              out_index,
   output logic                    out_last,
   output logic                    busy
);

   localparam int             BLK_W    = 16 * WORD_W;
   localparam int             BEATS    = ROUNDS / LANES;
   localparam logic [6:0]     LANES_7  = 7'(LANES);
   localparam logic [6:0]     LAST_CNT = 7'(BEATS - 1);

   if (!(((WORD_W == 32) && (ROUNDS == 64)) || ((WORD_W == 64) && (ROUNDS == 80)))
       || !((LANES == 1) || (LANES == 2) || (LANES == 4) || (LANES == 8) || (LANES == 16))
       || ((ROUNDS % LANES) != 0)) begin : g_param_check
      $error("sha2_msg_sched_stream: illegal WORD_W/ROUNDS/LANES combination");
   end

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [BLK_W-1:0]   window_q, window_d;
   logic [6:0]         cnt_q, cnt_d;
   logic [6:0]         idx_q, idx_d;
   logic               last_q, last_d;
   logic               accept_s;
   logic               fire_s;

   function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
      return (x >> n) | (x << (WORD_W - n));
   endfunction

   function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
      logic [WORD_W-1:0] r;
      if (WORD_W == 32) r = rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
      else              r = rotr(x, 1) ^ rotr(x, 8)  ^ (x >> 7);
      return r;
   endfunction

   function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
      logic [WORD_W-1:0] r;
      if (WORD_W == 32) r = rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
      else              r = rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
      return r;
   endfunction

   // Shift the window by LANES words, appending LANES freshly expanded words.
   // Later lanes chain on words produced earlier in the same beat.
   function automatic logic [BLK_W-1:0] advance(input logic [BLK_W-1:0] win);
      logic [WORD_W-1:0] ext [32];
      logic [BLK_W-1:0]  res;
      for (int i = 0; i < 32; i++) ext[i] = '0;
      for (int i = 0; i < 16; i++) ext[i] = win[(15 - i) * WORD_W +: WORD_W];
      for (int j = 0; j < LANES; j++)
         ext[16 + j] = sigma1(ext[14 + j]) + ext[9 + j] + sigma0(ext[1 + j]) + ext[j];
      res = '0;
      for (int i = 0; i < 16; i++) res[(15 - i) * WORD_W +: WORD_W] = ext[i + LANES];
      return res;
   endfunction

   assign accept_s = in_valid & in_ready;
   assign fire_s   = (state_q == EMIT) & out_ready & ~abort;

   // Upstream ready: free when idle, or on the last beat as it is being taken; never during abort.
   always_comb begin
      in_ready = 1'b0;
      if (abort)                in_ready = 1'b0;
      else if (state_q == IDLE) in_ready = 1'b1;
      else                      in_ready = last_q & out_ready;
   end

   // Next-state: abort flushes, accept loads a block, fire advances or retires.
   always_comb begin
      state_d  = state_q;
      window_d = window_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      last_d   = last_q;
      if (abort) begin
         state_d  = IDLE;
         window_d = '0;
         cnt_d    = 7'd0;
         idx_d    = 7'd0;
         last_d   = 1'b0;
      end else if (accept_s) begin
         state_d  = EMIT;
         window_d = in_block;
         cnt_d    = 7'd0;
         idx_d    = 7'd0;
         last_d   = 1'b0;
      end else if (fire_s) begin
         if (last_q) begin
            state_d  = IDLE;
            window_d = '0;
            cnt_d    = 7'd0;
            idx_d    = 7'd0;
            last_d   = 1'b0;
         end else begin
            window_d = advance(window_q);
            cnt_d    = cnt_q + 7'd1;
            idx_d    = idx_q + LANES_7;
            last_d   = ((cnt_q + 7'd1) == LAST_CNT);
         end
      end else begin
         state_d = state_q;
      end
   end

   // State, window and beat bookkeeping registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         window_q <= '0;
         cnt_q    <= 7'd0;
         idx_q    <= 7'd0;
         last_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         window_q <= window_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         last_q   <= last_d;
      end
   end

   assign out_valid = (state_q == EMIT);
   assign busy      = (state_q == EMIT);
   assign out_words = window_q[BLK_W-1 -: LANES*WORD_W];
   assign out_index = idx_q;
   assign out_last  = last_q;

endmodule

// File: tb/tb_sha2_msg_sched_stream.sv
// Self-checking bench for sha2_msg_sched_stream: four instances cover
// SHA-256 (LANES 1, 4, 8) and SHA-512 (LANES 2); a selector routes stimulus
// to one instance and a scoreboard queue holds the expected word stream.
module tb_sha2_msg_sched_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic [1:0]    sel;
   logic          in_valid, out_ready, abort, drop_valid;
   logic [1023:0] in_block;

   logic          d_in_valid [4];
   logic          d_abort    [4];
   logic          d_in_ready [4];
   logic          d_out_valid[4];
   logic          d_out_last [4];
   logic          d_busy     [4];
   logic [6:0]    d_out_index[4];
   logic [31:0]   w_a;
   logic [127:0]  w_b;
   logic [127:0]  w_c;
   logic [255:0]  w_d;

   logic          v_in_ready, v_out_valid, v_out_last, v_busy;
   logic [6:0]    v_out_index;
   logic [255:0]  v_words;

   int            checks = 0;
   int            failures = 0;
   int            cur_w, cur_r, cur_l;
   logic [63:0]   msg   [16];
   logic [63:0]   gold  [80];
   logic [63:0]   gold_b[80];
   logic [63:0]   cap   [80];
   logic [63:0]   exp_w [$];
   int            exp_i [$];

   sha2_msg_sched_stream #(.WORD_W(32), .ROUNDS(64), .LANES(1)) u_a (
      .clk(clk), .rst_n(rst_n), .abort(d_abort[0]), .in_valid(d_in_valid[0]),
      .in_ready(d_in_ready[0]), .in_block(in_block[511:0]), .out_valid(d_out_valid[0]),
      .out_ready(out_ready), .out_words(w_a), .out_index(d_out_index[0]),
      .out_last(d_out_last[0]), .busy(d_busy[0]));

   sha2_msg_sched_stream #(.WORD_W(64), .ROUNDS(80), .LANES(2)) u_b (
      .clk(clk), .rst_n(rst_n), .abort(d_abort[1]), .in_valid(d_in_valid[1]),
      .in_ready(d_in_ready[1]), .in_block(in_block), .out_valid(d_out_valid[1]),
      .out_ready(out_ready), .out_words(w_b), .out_index(d_out_index[1]),
      .out_last(d_out_last[1]), .busy(d_busy[1]));

   sha2_msg_sched_stream #(.WORD_W(32), .ROUNDS(64), .LANES(4)) u_c (
      .clk(clk), .rst_n(rst_n), .abort(d_abort[2]), .in_valid(d_in_valid[2]),
      .in_ready(d_in_ready[2]), .in_block(in_block[511:0]), .out_valid(d_out_valid[2]),
      .out_ready(out_ready), .out_words(w_c), .out_index(d_out_index[2]),
      .out_last(d_out_last[2]), .busy(d_busy[2]));

   sha2_msg_sched_stream #(.WORD_W(32), .ROUNDS(64), .LANES(8)) u_d (
      .clk(clk), .rst_n(rst_n), .abort(d_abort[3]), .in_valid(d_in_valid[3]),
      .in_ready(d_in_ready[3]), .in_block(in_block[511:0]), .out_valid(d_out_valid[3]),
      .out_ready(out_ready), .out_words(w_d), .out_index(d_out_index[3]),
      .out_last(d_out_last[3]), .busy(d_busy[3]));

   // Route the handshake inputs only to the selected instance.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         d_in_valid[i] = in_valid && (sel == 2'(i));
         d_abort[i]    = abort && (sel == 2'(i));
      end
   end

   // View the selected instance's outputs through one set of signals.
   always_comb begin
      v_in_ready  = d_in_ready[sel];
      v_out_valid = d_out_valid[sel];
      v_out_last  = d_out_last[sel];
      v_busy      = d_busy[sel];
      v_out_index = d_out_index[sel];
      case (sel)
         2'd0:    v_words = {224'h0, w_a};
         2'd1:    v_words = {128'h0, w_b};
         2'd2:    v_words = {128'h0, w_c};
         default: v_words = w_d;
      endcase
   end

   // ---------------- golden model ----------------
   function automatic logic [63:0] m_rotr(input logic [63:0] x, input int n);
      logic [63:0] r;
      if (cur_w == 32) r = {32'h0, (x[31:0] >> n) | (x[31:0] << (32 - n))};
      else             r = (x >> n) | (x << (64 - n));
      return r;
   endfunction

   function automatic logic [63:0] m_s0(input logic [63:0] x);
      if (cur_w == 32) return m_rotr(x, 7) ^ m_rotr(x, 18) ^ (x >> 3);
      else             return m_rotr(x, 1) ^ m_rotr(x, 8) ^ (x >> 7);
   endfunction

   function automatic logic [63:0] m_s1(input logic [63:0] x);
      if (cur_w == 32) return m_rotr(x, 17) ^ m_rotr(x, 19) ^ (x >> 10);
      else             return m_rotr(x, 19) ^ m_rotr(x, 61) ^ (x >> 6);
   endfunction

   task automatic build_gold();
      logic [63:0] mask;
      mask = (cur_w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
      for (int t = 0; t < 80; t++) gold[t] = 64'h0;
      for (int t = 0; t < 16; t++) gold[t] = msg[t] & mask;
      for (int t = 16; t < cur_r; t++)
         gold[t] = (m_s1(gold[t-2]) + gold[t-7] + m_s0(gold[t-15]) + gold[t-16]) & mask;
   endtask

   task automatic select_dut(input logic [1:0] s);
      sel = s;
      case (s)
         2'd0:    begin cur_w = 32; cur_r = 64; cur_l = 1; end
         2'd1:    begin cur_w = 64; cur_r = 80; cur_l = 2; end
         2'd2:    begin cur_w = 32; cur_r = 64; cur_l = 4; end
         default: begin cur_w = 32; cur_r = 64; cur_l = 8; end
      endcase
      for (int i = 0; i < 80; i++) cap[i] = 64'h0;
   endtask

   task automatic load_msg(input bit rnd);
      for (int i = 0; i < 16; i++) msg[i] = rnd ? {$urandom, $urandom} : 64'h0;
      if (!rnd) begin
         msg[0]  = (cur_w == 32) ? 64'h0000_0000_6162_6380 : 64'h6162_6380_0000_0000;
         msg[15] = 64'h0000_0000_0000_0018;
      end
      build_gold();
   endtask

   function automatic logic [1023:0] pack_msg();
      logic [1023:0] p;
      p = '0;
      for (int i = 0; i < 16; i++) begin
         if (cur_w == 32) p[(15 - i) * 32 +: 32] = msg[i][31:0];
         else             p[(15 - i) * 64 +: 64] = msg[i];
      end
      return p;
   endfunction

   // ---------------- stimulus / scoreboard tasks ----------------
   task automatic send_block(input string tag);
      int n;
      @(negedge clk);
      in_block = pack_msg();
      in_valid = 1'b1;
      #1;
      n = 0;
      while (v_in_ready !== 1'b1 && n < 50) begin
         @(negedge clk); #1; n++;
      end
      checks++;
      if (v_in_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s accept_timeout in_ready=%b want 1", tag, v_in_ready);
      end else begin
         for (int t = 0; t < cur_r; t++) begin exp_w.push_back(gold[t]); exp_i.push_back(t); end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (v_out_valid !== 1'b1 || v_out_index !== 7'd0) begin
         failures++;
         $display("FAIL %s first_beat valid=%b index=%0d want 1/0", tag, v_out_valid, v_out_index);
      end
   endtask

   task automatic consume(input string tag, input int nbeats, input int stall_pct, input int bound);
      int           beats, cyc, ei, first_ei;
      logic         held;
      logic [255:0] h_words, sh;
      logic [6:0]   h_index;
      logic         h_last;
      logic [63:0]  mask, got, ew;
      beats = 0; cyc = 0; held = 1'b0; first_ei = -1;
      h_words = '0; h_index = 7'd0; h_last = 1'b0;
      mask = (cur_w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
      while (beats < nbeats && cyc < bound) begin
         @(negedge clk);
         cyc++;
         if (drop_valid) begin in_valid = 1'b0; drop_valid = 1'b0; end
         if (held) begin
            checks++;
            if (v_out_valid !== 1'b1 || v_words !== h_words || v_out_index !== h_index || v_out_last !== h_last) begin
               failures++;
               $display("FAIL %s stall_hold index=%0d last=%b want %0d/%b", tag, v_out_index, v_out_last, h_index, h_last);
            end
         end
         checks++;
         if (v_busy !== v_out_valid) begin
            failures++;
            $display("FAIL %s busy=%b want %b", tag, v_busy, v_out_valid);
         end
         out_ready = ($urandom_range(99) >= stall_pct);
         #1;
         if (v_out_valid === 1'b1) begin
            checks++;
            if (v_in_ready !== (v_out_last & out_ready)) begin
               failures++;
               $display("FAIL %s in_ready=%b want %b", tag, v_in_ready, v_out_last & out_ready);
            end
         end
         held = v_out_valid && !out_ready;
         h_words = v_words; h_index = v_out_index; h_last = v_out_last;
         if (in_valid && v_in_ready) begin
            for (int t = 0; t < cur_r; t++) begin exp_w.push_back(gold_b[t]); exp_i.push_back(t); end
            drop_valid = 1'b1;
         end
         if (v_out_valid && out_ready) begin
            for (int k = 0; k < cur_l; k++) begin
               sh  = v_words >> ((cur_l - 1 - k) * cur_w);
               got = sh[63:0] & mask;
               checks++;
               if (exp_w.size() == 0) begin
                  failures++;
                  $display("FAIL %s extra_word got=%h want none", tag, got);
               end else begin
                  ew = exp_w.pop_front();
                  ei = exp_i.pop_front();
                  if (k == 0) first_ei = ei;
                  cap[ei] = got;
                  if (got !== ew || (k == 0 && v_out_index !== 7'(ei))) begin
                     failures++;
                     $display("FAIL %s word W%0d got=%h index=%0d want %h index=%0d", tag, ei, got, v_out_index, ew, ei);
                  end
               end
            end
            checks++;
            if (v_out_last !== (first_ei == cur_r - cur_l)) begin
               failures++;
               $display("FAIL %s out_last index=%0d got=%b want %b", tag, v_out_index, v_out_last, first_ei == cur_r - cur_l);
            end
            beats++;
         end
      end
      checks++;
      if (beats < nbeats) begin
         failures++;
         $display("FAIL %s beat_count got=%0d want %0d within %0d cycles", tag, beats, nbeats, bound);
      end
   endtask

   task automatic check_idle(input string tag);
      @(negedge clk); #1;
      checks++;
      if (v_out_valid !== 1'b0 || v_busy !== 1'b0 || v_out_last !== 1'b0 ||
          v_out_index !== 7'd0 || v_words !== 256'h0 || v_in_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s idle valid=%b busy=%b last=%b index=%0d in_ready=%b words=%h want 0/0/0/0/1/0",
                  tag, v_out_valid, v_busy, v_out_last, v_out_index, v_in_ready, v_words);
      end
      checks++;
      if (exp_w.size() != 0) begin
         failures++;
         $display("FAIL %s leftover_words got=%0d want 0", tag, exp_w.size());
      end
   endtask

   task automatic check_cap(input string tag, input int t, input logic [63:0] want);
      checks++;
      if (cap[t] !== want) begin
         failures++;
         $display("FAIL %s W%0d got=%h want %h", tag, t, cap[t], want);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int s = 0; s < 4; s++) begin
         select_dut(2'(s));
         check_idle("reset");
      end
   endtask

   task automatic test_sha256_abc();
      select_dut(2'd0);
      load_msg(1'b0);
      send_block("abc256");
      consume("abc256", 64, 0, 64);
      check_idle("abc256_end");
      check_cap("abc256", 16, 64'h0000_0000_6162_6380);
      check_cap("abc256", 17, 64'h0000_0000_000F_0000);
      check_cap("abc256", 63, 64'h0000_0000_12B1_EDEB);
   endtask

   task automatic test_sha512_abc();
      select_dut(2'd1);
      load_msg(1'b0);
      send_block("abc512");
      consume("abc512", 40, 0, 40);
      check_idle("abc512_end");
      check_cap("abc512", 16, 64'h6162_6380_0000_0000);
      check_cap("abc512", 17, 64'h0003_0000_0000_00C0);
   endtask

   task automatic test_backpressure();
      select_dut(2'd2);
      load_msg(1'b1);
      send_block("bp");
      consume("bp", 16, 50, 600);
      out_ready = 1'b1;
      check_idle("bp_end");
   endtask

   task automatic test_back_to_back();
      select_dut(2'd3);
      load_msg(1'b1);
      send_block("b2b");
      load_msg(1'b1);
      gold_b   = gold;
      in_block = pack_msg();
      in_valid = 1'b1;
      consume("b2b", 16, 0, 16);
      in_valid   = 1'b0;
      drop_valid = 1'b0;
      check_idle("b2b_end");
   endtask

   task automatic test_abort();
      select_dut(2'd0);
      load_msg(1'b0);
      send_block("abort");
      consume("abort_pre", 20, 0, 20);
      @(negedge clk);
      checks++;
      if (v_out_valid !== 1'b1 || v_out_index !== 7'd20) begin
         failures++;
         $display("FAIL abort_pos valid=%b index=%0d want 1/20", v_out_valid, v_out_index);
      end
      out_ready = 1'b0;
      abort     = 1'b1;
      #1;
      checks++;
      if (v_in_ready !== 1'b0) begin
         failures++;
         $display("FAIL abort_in_ready got=%b want 0", v_in_ready);
      end
      @(posedge clk); #1;
      abort = 1'b0;
      exp_w.delete();
      exp_i.delete();
      check_idle("abort_flush");
      send_block("abort_fresh");
      consume("abort_fresh", 64, 0, 64);
      check_idle("abort_fresh_end");
      check_cap("abort_fresh", 63, 64'h0000_0000_12B1_EDEB);
   endtask

   task automatic test_reset_midblock();
      select_dut(2'd0);
      load_msg(1'b1);
      send_block("rst_mid");
      consume("rst_mid_pre", 10, 0, 10);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (v_out_valid !== 1'b0 || v_busy !== 1'b0 || v_out_last !== 1'b0 ||
          v_out_index !== 7'd0 || v_words !== 256'h0) begin
         failures++;
         $display("FAIL rst_async valid=%b busy=%b last=%b index=%0d words=%h want all 0",
                  v_out_valid, v_busy, v_out_last, v_out_index, v_words);
      end
      @(negedge clk);
      rst_n = 1'b1;
      exp_w.delete();
      exp_i.delete();
      check_idle("rst_release");
      load_msg(1'b0);
      send_block("rst_fresh");
      consume("rst_fresh", 64, 0, 64);
      check_idle("rst_fresh_end");
      check_cap("rst_fresh", 17, 64'h0000_0000_000F_0000);
   endtask

   initial begin
      sel = 2'd0; in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0; drop_valid = 1'b0;
      in_block = '0; rst_n = 1'b0;
      cur_w = 32; cur_r = 64; cur_l = 1;
      test_reset();
      test_sha256_abc();
      test_sha512_abc();
      test_backpressure();
      test_back_to_back();
      test_abort();
      test_reset_midblock();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sha2_msg_sched_stream.md
Name: sha2_msg_sched_stream

Overview:
- Parametrised SHA-2 message-schedule generator. Accepts one 16-word message block and streams the full expansion W[0..ROUNDS-1] as LANES words per beat.
- Covers SHA-224/256 (32-bit words, 64 rounds) and SHA-384/512 (64-bit words, 80 rounds).
- Uses valid/ready handshakes on both sides, with full output backpressure and zero-bubble back-to-back blocks.
- Sits between the padding/block assembler and the compression round engine.

Parameters:
- WORD_W, 32, word width. Legal values: 32 (SHA-256 family) or 64 (SHA-512 family).
- ROUNDS, 64, words emitted per block. Must be 64 when WORD_W=32 and 80 when WORD_W=64.
- LANES, 1, words per output beat. Legal values: 1, 2, 4, 8, 16. Must divide ROUNDS.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- abort  in  1  synchronous flush of the block in flight
- in_valid  in  1  block available
- in_ready  out  1  block can be accepted this cycle
- in_block  in  16*WORD_W  message block; word 0 occupies the MSBs [16*WORD_W-1 -: WORD_W]
- out_valid  out  1  beat valid
- out_ready  in  1  consumer accepts beat
- out_words  out  LANES*WORD_W  W[out_index+k] for lane k; lane 0 in the MSBs
- out_index  out  7  round index of lane 0 (0..ROUNDS-LANES)
- out_last  out  1  final beat of block
- busy  out  1  block in flight (same as out_valid)

Behaviour:
- Reset values: out_valid=0, out_words=0, out_index=0, out_last=0, busy=0. State is IDLE, so in_ready=1. The 16-word window and the beat counter are cleared.
- States:
  - IDLE: out_valid=0, in_ready=1.
  - EMIT: out_valid=1.
- IDLE -> EMIT on in_valid. The block loads into the 16-word window (window[i]=W[i]). The counter is set to 0.
- Latency: block accepted at edge N; beat 0 (W[0..LANES-1], out_index=0) is valid after edge N.
- Beat advance in EMIT on out_valid&&out_ready:
  - counter+1; out_index += LANES.
  - The window shifts by LANES and appends LANES new words W[t+16+j] = s1(W[t+14+j]) + W[t+9+j] + s0(W[t+1+j]) + W[t+j], mod 2^WORD_W.
  - For j>=2 the new word uses W[t+14+j] computed in the same beat, i.e. combinational chaining within the beat.
- out_words is driven directly from window[0..LANES-1], which is registered.
- Sigma functions:
  - WORD_W=32: s0 = ROTR7 ^ ROTR18 ^ SHR3; s1 = ROTR17 ^ ROTR19 ^ SHR10.
  - WORD_W=64: s0 = ROTR1 ^ ROTR8 ^ SHR7; s1 = ROTR19 ^ ROTR61 ^ SHR6.
- Beats per block = ROUNDS/LANES. out_last=1 when counter = ROUNDS/LANES-1.
- Last-beat handshake:
  - If in_valid is also 1: in_ready=1 (combinational: IDLE, or EMIT && out_last && out_ready). The new block loads, the FSM stays in EMIT with out_index=0 next cycle. No bubble.
  - Otherwise: -> IDLE, out_valid=0, out_words/out_index/out_last return to 0.
- Backpressure: while out_valid && !out_ready, out_words, out_index and out_last hold stable. The window and counter do not advance. in_ready=0 unless this is the last beat with out_ready=1.
- in_valid in EMIT on a non-last beat is ignored; the upstream must hold its block.
- abort has priority over all handshakes: next cycle IDLE, outputs return to reset values, window cleared. A beat presented in the abort cycle is not considered transferred. in_ready=0 during the abort cycle.
- Async reset mid-block: immediate return to reset values. There is no partial resume.
- Parameter checks: an illegal WORD_W/ROUNDS/LANES combination raises an elaboration error.

Test Plan:
- WORD_W=32, LANES=1, SHA-256 "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), out_ready=1 -> 64 beats on consecutive cycles after the accept edge. W16=0x61626380, W17=0x000F0000, W63=0x12B1EDEB. out_last only on out_index=63. Then out_valid=0 and in_ready=1.
- WORD_W=64, ROUNDS=80, LANES=2, SHA-512 "abc" block (W0=0x6162638000000000, W15=0x18) -> 40 beats. Beat 8 carries W16=0x6162638000000000 and W17=0x00030000000000C0. All 80 words match the golden model.
- LANES=4, out_ready toggled pseudo-randomly (~50%) -> each beat holds stable while stalled. Words and indices 0,4,...,60 in order, with no duplicates or drops.
- Two blocks with in_valid held high, out_ready=1, LANES=8 -> second block beat 0 appears the cycle after the first block's out_index=56 beat. 16 beats total, no idle cycle between blocks.
- abort asserted at out_index=20 with out_ready=0 -> next cycle out_valid=0, out_index=0, in_ready=1. A fresh block afterwards reproduces the golden sequence from W0.
- rst_n pulsed low mid-block (async, between edges) -> outputs go to zero immediately. After release, in_ready=1 and the first accepted block streams correctly.
